midi_event_encoder: RTL and testbench

Transmit-side counterpart of the MIDI input decode path. Accepts channel-voice events (note on/off, controller, program change, pitch bend) from the synth engine or CPU over a valid/ready handshake, and buffers them in a small FIFO. Serialises each event into MIDI bytes, applying running status with periodic refresh. Drives the MIDI_UART transmit byte interface (midi_out_ready / midi_send_byte / midi_out_data).

---
 rtl/midi_event_encoder.sv | 184 ++++++++++++++++++
 tb/tb_midi_event_encoder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : midi_event_encoder
// Purpose  : Queues MIDI channel-voice events and serialises them into UART
//            bytes, with running status and periodic status refresh.
// Revision : 1.0  initial release
// ============================================================================
module midi_event_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter bit RS_ENABLE  = 1'b1,
    parameter int RS_REFRESH = 50_000_000
) (
    input  logic       reg_clk,
    input  logic       reg_reset,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [2:0] ev_type,
    input  logic [3:0] ev_ch,
    input  logic [6:0] ev_d1,
    input  logic [6:0] ev_d2,
    input  logic       midi_out_ready,
    output logic       midi_send_byte,
    output logic [7:0] midi_out_data,
    output logic       busy,
    output logic       ev_dropped
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = $clog2(RS_REFRESH + 1);
    localparam int EW = 21;
    localparam logic [CW-1:0] C_DEPTH   = CW'(FIFO_DEPTH);
    localparam logic [RW-1:0] C_REFRESH = RW'(RS_REFRESH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STATUS = 3'd2,
        S_DATA1  = 3'd3,
        S_DATA2  = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ev_ready_q;
    logic          push, pop;

    state_t        state_q, after_q;
    logic [2:0]    type_q;
    logic [3:0]    ch_q;
    logic [6:0]    d1_q, d2_q;
    logic [7:0]    last_status_q;
    logic          ls_valid_q;
    logic [RW-1:0] refresh_q;
    logic          send_q, dropped_q;
    logic [7:0]    data_q;

    logic [7:0]    status;
    logic          status_ok;
    logic          rs_hit;

    always_comb begin
        push    = ev_valid & ev_ready_q;
        pop     = (state_q == S_IDLE) && (count_q != '0);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        status_ok = 1'b1;
        case (type_q)
            3'd0:    status = {4'h8, ch_q};
            3'd1:    status = {4'h9, ch_q};
            3'd2:    status = {4'hB, ch_q};
            3'd3:    status = {4'hC, ch_q};
            3'd4:    status = {4'hE, ch_q};
            default: begin
                status    = 8'h00;
                status_ok = 1'b0;
            end
        endcase
        rs_hit = RS_ENABLE && ls_valid_q && (last_status_q == status)
                 && (refresh_q < C_REFRESH);
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge reg_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {ev_type, ev_ch, ev_d1, ev_d2};
        end
    end

    always_ff @(posedge reg_clk) begin
        if (reg_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ev_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            ev_ready_q <= (count_d != C_DEPTH);
        end
    end

    always_ff @(posedge reg_clk) begin
        if (reg_reset) begin
            state_q       <= S_IDLE;
            after_q       <= S_IDLE;
            type_q        <= '0;
            ch_q          <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            last_status_q <= '0;
            ls_valid_q    <= 1'b0;
            refresh_q     <= '0;
            send_q        <= 1'b0;
            dropped_q     <= 1'b0;
            data_q        <= 8'h00;
        end else begin
            send_q    <= 1'b0;
            dropped_q <= 1'b0;
            if (refresh_q != C_REFRESH) refresh_q <= refresh_q + RW'(1);
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {type_q, ch_q, d1_q, d2_q} <= fifo_q[rd_ptr_q];
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!status_ok) begin
                        dropped_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (rs_hit) begin
                        state_q <= S_DATA1;
                    end else begin
                        state_q <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    if (midi_out_ready) begin
                        send_q        <= 1'b1;
                        data_q        <= status;
                        last_status_q <= status;
                        ls_valid_q    <= 1'b1;
                        refresh_q     <= '0;
                        after_q       <= S_DATA1;
                        state_q       <= S_GAP;
                    end
                end
                S_DATA1: begin
                    if (midi_out_ready) begin
                        send_q  <= 1'b1;
                        data_q  <= {1'b0, d1_q};
                        after_q <= (type_q == 3'd3) ? S_IDLE : S_DATA2;
                        state_q <= S_GAP;
                    end
                end
                S_DATA2: begin
                    if (midi_out_ready) begin
                        send_q  <= 1'b1;
                        data_q  <= {1'b0, d2_q};
                        after_q <= S_IDLE;
                        state_q <= S_GAP;
                    end
                end
                // Idle cycle after every strobe gives the UART time to drop ready.
                S_GAP:   state_q <= after_q;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ev_ready       = ev_ready_q;
    assign midi_send_byte = send_q;
    assign midi_out_data  = data_q;
    assign ev_dropped     = dropped_q;
    assign busy           = (count_q != '0) || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_midi_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_event_encoder
// Purpose  : Self-checking bench for midi_event_encoder (vectors, corner
//            sequences and a randomized run against a byte-stream model).
// Revision : 1.0  initial release
// ============================================================================
module tb_midi_event_encoder;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [2:0]  t;
        logic [3:0]  ch;
        logic [6:0]  d1;
        logic [6:0]  d2;
        int          n;
        logic [23:0] bytes;
        int          drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       ev_valid;
    logic [2:0] ev_type;
    logic [3:0] ev_ch;
    logic [6:0] ev_d1, ev_d2;
    logic       midi_out_ready;
    logic       rdy [3];
    logic       snd [3];
    logic       bsy [3];
    logic       drp [3];
    logic [7:0] dat [3];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    bit   rnd_ready = 1'b0;

    bq_t  qa, qb, qc;
    int   ta[$];
    int   drops [3] = '{0, 0, 0};
    int   b2b = 0;
    logic prev [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_event_encoder #(.FIFO_DEPTH(4), .RS_ENABLE(1'b1), .RS_REFRESH(100)) u_a (
        .reg_clk(clk), .reg_reset(rst), .ev_valid(ev_valid && (sel == 2'd0)),
        .ev_ready(rdy[0]), .ev_type(ev_type), .ev_ch(ev_ch), .ev_d1(ev_d1), .ev_d2(ev_d2),
        .midi_out_ready(midi_out_ready), .midi_send_byte(snd[0]), .midi_out_data(dat[0]),
        .busy(bsy[0]), .ev_dropped(drp[0]));

    midi_event_encoder #(.FIFO_DEPTH(4), .RS_ENABLE(1'b0), .RS_REFRESH(100)) u_b (
        .reg_clk(clk), .reg_reset(rst), .ev_valid(ev_valid && (sel == 2'd1)),
        .ev_ready(rdy[1]), .ev_type(ev_type), .ev_ch(ev_ch), .ev_d1(ev_d1), .ev_d2(ev_d2),
        .midi_out_ready(midi_out_ready), .midi_send_byte(snd[1]), .midi_out_data(dat[1]),
        .busy(bsy[1]), .ev_dropped(drp[1]));

    midi_event_encoder #(.FIFO_DEPTH(4), .RS_ENABLE(1'b1), .RS_REFRESH(1_000_000)) u_c (
        .reg_clk(clk), .reg_reset(rst), .ev_valid(ev_valid && (sel == 2'd2)),
        .ev_ready(rdy[2]), .ev_type(ev_type), .ev_ch(ev_ch), .ev_d1(ev_d1), .ev_d2(ev_d2),
        .midi_out_ready(midi_out_ready), .midi_send_byte(snd[2]), .midi_out_data(dat[2]),
        .busy(bsy[2]), .ev_dropped(drp[2]));

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (snd[k] && prev[k]) b2b++;
            if (drp[k]) drops[k]++;
            prev[k] = snd[k];
        end
        if (snd[0]) begin
            qa.push_back(dat[0]);
            ta.push_back(cyc);
        end
        if (snd[1]) qb.push_back(dat[1]);
        if (snd[2]) qc.push_back(dat[2]);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rnd_ready) midi_out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        ev_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int k, input logic [2:0] t, input logic [3:0] c,
                        input logic [6:0] a, input logic [6:0] b, output int pc);
        bit ok;
        ok = 1'b0;
        pc = 0;
        tick();
        sel = 2'(k);
        ev_type = t; ev_ch = c; ev_d1 = a; ev_d2 = b;
        ev_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (rdy[k]) begin
                pc = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        ev_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!bsy[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        tick();
        tick();
    endtask

    task automatic cmp_seq(input string name, input bq_t got, input int base, input bq_t exp);
        chk({name, "_len"}, 32'(got.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got.size())
                chk($sformatf("%s_b%0d", name, i), 32'(got[base + i]), 32'(exp[i]));
        end
    endtask

    initial begin
        vec_t tbl [9];
        bq_t  exp;
        int   pc, pc1, b, db;
        int   hi [5] = '{0, 1, 3, 4, 6};
        logic [7:0] ls;
        bit   lsv;
        int   dexp;
        int   r;
        logic [2:0] t;
        logic [3:0] c;
        logic [6:0] a, d;
        logic [7:0] st;

        tbl[0] = '{3'd1, 4'd0, 7'h3C, 7'h64, 3, 24'h903C64, 0};
        tbl[1] = '{3'd1, 4'd0, 7'h40, 7'h00, 2, 24'h400000, 0};
        tbl[2] = '{3'd2, 4'd5, 7'h07, 7'h7F, 3, 24'hB5077F, 0};
        tbl[3] = '{3'd2, 4'd5, 7'h0A, 7'h40, 2, 24'h0A4000, 0};
        tbl[4] = '{3'd3, 4'd3, 7'h05, 7'h11, 2, 24'hC30500, 0};
        tbl[5] = '{3'd4, 4'd15, 7'h00, 7'h40, 3, 24'hEF0040, 0};
        tbl[6] = '{3'd0, 4'd9, 7'h3C, 7'h00, 3, 24'h893C00, 0};
        tbl[7] = '{3'd6, 4'd9, 7'h22, 7'h33, 0, 24'h000000, 1};
        tbl[8] = '{3'd0, 4'd9, 7'h3D, 7'h10, 2, 24'h3D1000, 0};

        rst = 1'b1; sel = 2'd0; ev_valid = 1'b0;
        ev_type = '0; ev_ch = '0; ev_d1 = '0; ev_d2 = '0;
        midi_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ev_ready", 32'(rdy[0]), 32'd1);
        chk("rst_send", 32'(snd[0]), 32'd0);
        chk("rst_data", 32'(dat[0]), 32'h00);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_dropped", 32'(drp[0]), 32'd0);

        // Back-to-back note-ons: latency, strobe spacing, running status.
        b = qa.size();
        push(0, 3'd1, 4'd0, 7'h3C, 7'h64, pc1);
        push(0, 3'd1, 4'd0, 7'h40, 7'h00, pc);
        wait_idle(0);
        exp = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00};
        cmp_seq("b2b_rs", qa, b, exp);
        if (ta.size() >= b + 3) begin
            chk("first_latency", 32'(ta[b] - pc1), 32'd4);
            chk("strobe_gap1", 32'(ta[b + 1] - ta[b]), 32'd2);
            chk("strobe_gap2", 32'(ta[b + 2] - ta[b + 1]), 32'd2);
        end else begin
            chk("latency_bytes", 32'(ta.size() - b), 32'd3);
        end
        chk("busy_after", 32'(bsy[0]), 32'd0);

        // Running status disabled.
        do_reset();
        b = qb.size();
        push(1, 3'd1, 4'd0, 7'h3C, 7'h64, pc);
        push(1, 3'd1, 4'd0, 7'h40, 7'h00, pc);
        wait_idle(1);
        exp = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h40, 8'h00};
        cmp_seq("rs_off", qb, b, exp);

        // Vector table, one event at a time.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            b = qa.size();
            db = drops[0];
            push(0, tbl[i].t, tbl[i].ch, tbl[i].d1, tbl[i].d2, pc);
            wait_idle(0);
            exp.delete();
            for (int j = 0; j < tbl[i].n; j++) exp.push_back(tbl[i].bytes[23 - 8 * j -: 8]);
            cmp_seq($sformatf("vec%0d", i), qa, b, exp);
            chk($sformatf("vec%0d_drop", i), 32'(drops[0] - db), 32'(tbl[i].drop));
        end

        // Refresh: same status after a long idle gap is re-sent.
        do_reset();
        b = qa.size();
        push(0, 3'd1, 4'd0, 7'h3C, 7'h64, pc);
        wait_idle(0);
        repeat (150) tick();
        push(0, 3'd1, 4'd0, 7'h3C, 7'h00, pc);
        wait_idle(0);
        exp = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00};
        cmp_seq("refresh", qa, b, exp);

        // Fill with the UART stalled: one event sits in the working registers,
        // so FIFO_DEPTH+1 pushes are accepted before ev_ready drops.
        do_reset();
        midi_out_ready = 1'b0;
        b = qa.size();
        push(0, 3'd1, 4'd1, 7'h30, 7'h40, pc);
        push(0, 3'd1, 4'd1, 7'h31, 7'h41, pc);
        push(0, 3'd3, 4'd3, 7'h05, 7'h00, pc);
        push(0, 3'd4, 4'd15, 7'h00, 7'h40, pc);
        chk("full_rdy_after4", 32'(rdy[0]), 32'd1);
        push(0, 3'd2, 4'd2, 7'h01, 7'h02, pc);
        chk("full_rdy_after5", 32'(rdy[0]), 32'd0);
        tick();
        ev_type = 3'd2; ev_ch = 4'd2; ev_d1 = 7'h03; ev_d2 = 7'h04; ev_valid = 1'b1;
        repeat (8) tick();
        chk("held_rdy", 32'(rdy[0]), 32'd0);
        chk("held_nobytes", 32'(qa.size() - b), 32'd0);
        midi_out_ready = 1'b1;
        push(0, 3'd2, 4'd2, 7'h03, 7'h04, pc);
        wait_idle(0);
        exp = '{8'h91, 8'h30, 8'h40, 8'h31, 8'h41, 8'hC3, 8'h05,
                8'hEF, 8'h00, 8'h40, 8'hB2, 8'h01, 8'h02, 8'h03, 8'h04};
        cmp_seq("full", qa, b, exp);

        // Reset while waiting in DATA1 with two events queued.
        do_reset();
        midi_out_ready = 1'b0;
        b = qa.size();
        push(0, 3'd1, 4'd0, 7'h3C, 7'h64, pc);
        push(0, 3'd1, 4'd0, 7'h3D, 7'h01, pc);
        push(0, 3'd1, 4'd0, 7'h3E, 7'h02, pc);
        repeat (4) tick();
        midi_out_ready = 1'b1;
        tick();
        midi_out_ready = 1'b0;
        repeat (4) tick();
        chk("midrst_pre_bytes", 32'(qa.size() - b), 32'd1);
        chk("midrst_pre_busy", 32'(bsy[0]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        midi_out_ready = 1'b1;
        chk("midrst_rdy", 32'(rdy[0]), 32'd1);
        chk("midrst_busy", 32'(bsy[0]), 32'd0);
        chk("midrst_send", 32'(snd[0]), 32'd0);
        repeat (20) tick();
        chk("midrst_no_more", 32'(qa.size() - b), 32'd1);
        b = qa.size();
        push(0, 3'd1, 4'd0, 7'h3F, 7'h05, pc);
        wait_idle(0);
        exp = '{8'h90, 8'h3F, 8'h05};
        cmp_seq("post_rst", qa, b, exp);

        // Randomized run against a byte-stream model.
        do_reset();
        b = qc.size();
        db = drops[2];
        exp.delete();
        lsv = 1'b0;
        ls = 8'h00;
        dexp = 0;
        rnd_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 15));
            t = (r < 14) ? 3'(r % 5) : 3'(5 + (r % 3));
            c = 4'($urandom_range(0, 3));
            a = 7'($urandom_range(0, 127));
            d = 7'($urandom_range(0, 127));
            push(2, t, c, a, d, pc);
            if (t > 3'd4) begin
                dexp++;
            end else begin
                st = 8'(128 + 16 * hi[t] + int'(c));
                if (!(lsv && ls == st)) begin
                    exp.push_back(st);
                    ls = st;
                    lsv = 1'b1;
                end
                exp.push_back({1'b0, a});
                if (t != 3'd3) exp.push_back({1'b0, d});
            end
            repeat ($urandom_range(0, 4)) tick();
        end
        rnd_ready = 1'b0;
        midi_out_ready = 1'b1;
        wait_idle(2);
        cmp_seq("rand", qc, b, exp);
        chk("rand_drops", 32'(drops[2] - db), 32'(dexp));

        chk("no_back_to_back", 32'(b2b), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
